// File: rtl/ascensor_pkg.sv
// ascensor_pkg: constants shared by the elevator controller blocks.
//   N_BOTONES        : number of request buttons (cabin + hall up + hall down)
//   BASE_CABINA/SUBE/BAJA : first bit of each button group inside the vector
//   mascara_servicio : request bits served while the door is open at a floor
package ascensor_pkg;

    localparam int unsigned PISOS_ASCENSOR = 4;
    localparam int unsigned N_BOTONES      = 3 * PISOS_ASCENSOR - 2;
    localparam int unsigned BASE_CABINA    = 0;
    localparam int unsigned BASE_SUBE      = 4;
    localparam int unsigned BASE_BAJA      = 7;

    localparam logic [N_BOTONES-1:0] BIT_UNO = N_BOTONES'(1);

    // Cabin bit always; hall-up only below the top floor; hall-down only
    // above the ground floor (hall-down group starts at floor 1).
    function automatic logic [N_BOTONES-1:0] mascara_servicio(input logic [1:0] piso);
        logic [N_BOTONES-1:0] m;
        m = '0;
        m = m | (BIT_UNO << (BASE_CABINA + 32'(piso)));
        if (32'(piso) < PISOS_ASCENSOR - 1)
            m = m | (BIT_UNO << (BASE_SUBE + 32'(piso)));
        if (piso != 2'd0)
            m = m | (BIT_UNO << (BASE_BAJA + 32'(piso) - 1));
        return m;
    endfunction

endpackage

// File: rtl/antirrebote.sv
// antirrebote: one push-button conditioning chain.
//   2-flop synchronizer -> debounce filter (level) -> previous level -> edge.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   boton   : raw asynchronous button, active-high
//   sube    : one-cycle rising-edge pulse of the debounced level
// Configuration: with ANTIRREBOTE_EN defined the level passes through a
// DEB_CICLOS-sample stability filter; otherwise the synchronized level is
// used directly and DEB_CICLOS is ignored.
module antirrebote #(
    parameter int unsigned DEB_CICLOS = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic boton,
    output logic sube
);

    logic sinc1_q, sinc2_q;
    logic nivel;
    logic nivel_prev_q;

`ifdef ANTIRREBOTE_EN
    logic       nivel_q, nivel_d;
    logic [7:0] cnt_q, cnt_d;

    // Counter measures how long s2 has disagreed with the accepted level;
    // any agreement restarts it, so short pulses and gaps never win.
    always_comb begin
        nivel_d = nivel_q;
        cnt_d   = '0;
        if (sinc2_q != nivel_q) begin
            if (cnt_q == 8'(DEB_CICLOS - 1)) begin
                nivel_d = sinc2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nivel_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            nivel_q <= nivel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign nivel = nivel_q;
`else
    assign nivel = sinc2_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sinc1_q      <= 1'b0;
            sinc2_q      <= 1'b0;
            nivel_prev_q <= 1'b0;
        end else begin
            sinc1_q      <= boton;
            sinc2_q      <= sinc1_q;
            nivel_prev_q <= nivel;
        end
    end

    assign sube = nivel & ~nivel_prev_q;

endmodule

// File: rtl/interfaz_entrada.sv
// interfaz_entrada: elevator input interface. Conditions the raw buttons and
// latches them as pending floor requests, cleared when a floor is served.
// Ports:
//   clk            : system clock, rising edge
//   reset_n        : asynchronous active-low reset
//   botones        : raw buttons [3:0] cabin, [6:4] hall up, [9:7] hall down
//   piso_actual    : floor the car is at
//   puerta_abierta : door open at piso_actual (that floor is being served)
//   pisos          : latched pending requests, same mapping as botones
//   nuevo          : one-cycle pulse when any pisos bit goes 0->1
// Configuration: ANTIRREBOTE_EN enables the debounce filter in antirrebote.
module interfaz_entrada
    import ascensor_pkg::*;
#(
    parameter int unsigned N_PISOS    = 4,
    parameter int unsigned DEB_CICLOS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_BOTONES-1:0]         botones,
    input  logic [$clog2(N_PISOS)-1:0]   piso_actual,
    input  logic                         puerta_abierta,
    output logic [N_BOTONES-1:0]         pisos,
    output logic                         nuevo
);

    logic [N_BOTONES-1:0] sube;
    logic [N_BOTONES-1:0] limpiar;
    logic [N_BOTONES-1:0] pisos_q, pisos_d;
    logic                 nuevo_q, nuevo_d;

    for (genvar i = 0; i < N_BOTONES; i++) begin : g_boton
        antirrebote #(
            .DEB_CICLOS(DEB_CICLOS)
        ) u_antirrebote (
            .clk    (clk),
            .reset_n(reset_n),
            .boton  (botones[i]),
            .sube   (sube[i])
        );
    end

    // Clear is applied after set so a request for the floor being served
    // is dropped immediately and never announced.
    always_comb begin
        limpiar = '0;
        if (puerta_abierta)
            limpiar = mascara_servicio(piso_actual);
        pisos_d = (pisos_q | sube) & ~limpiar;
        nuevo_d = |(sube & ~pisos_q & ~limpiar);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pisos_q <= '0;
            nuevo_q <= 1'b0;
        end else begin
            pisos_q <= pisos_d;
            nuevo_q <= nuevo_d;
        end
    end

    assign pisos = pisos_q;
    assign nuevo = nuevo_q;

endmodule

// File: tb/tb_interfaz_entrada.sv
module tb_interfaz_entrada;

    localparam int DEB = 4;
`ifdef ANTIRREBOTE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif

    logic       clk;
    logic       reset_n;
    logic [9:0] botones;
    logic [1:0] piso_actual;
    logic       puerta_abierta;
    logic [9:0] pisos;
    logic       nuevo;

    int total = 0;
    int bad   = 0;
    int prints = 0;

    interfaz_entrada #(
        .N_PISOS   (4),
        .DEB_CICLOS(DEB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .botones       (botones),
        .piso_actual   (piso_actual),
        .puerta_abierta(puerta_abierta),
        .pisos         (pisos),
        .nuevo         (nuevo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    bit         s1m[10], s2m[10], lvl[10], prev[10];
    int         run[10];
    bit [9:0]   pm;
    bit         nm;
    bit [10:0]  expq[$];

    function automatic bit [9:0] served(input int f);
        bit [9:0] c;
        c = '0;
        c[f] = 1'b1;               // cabin button of floor f
        if (f < 3) c[4 + f] = 1'b1; // hall up exists on floors 0..2
        if (f > 0) c[6 + f] = 1'b1; // hall down exists on floors 1..3
        return c;
    endfunction

    always @(posedge clk) begin
        bit [9:0] rise, clr;
        if (!reset_n) begin
            for (int i = 0; i < 10; i++) begin
                s1m[i] = 0; s2m[i] = 0; lvl[i] = 0; prev[i] = 0; run[i] = 0;
            end
            pm = '0;
            nm = 1'b0;
        end else begin
            rise = '0;
            for (int i = 0; i < 10; i++) begin
`ifdef ANTIRREBOTE_EN
                rise[i] = lvl[i] & ~prev[i];
                prev[i] = lvl[i];
                if (s2m[i] != lvl[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        lvl[i] = s2m[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
`else
                rise[i] = s2m[i] & ~prev[i];
                prev[i] = s2m[i];
`endif
                s2m[i] = s1m[i];
                s1m[i] = botones[i];
            end
            clr = puerta_abierta ? served(int'(piso_actual)) : 10'b0;
            nm  = |(rise & ~pm & ~clr);
            pm  = (pm | rise) & ~clr;
        end
        expq.push_back({pm, nm});
    end

    // ---------------- monitor ----------------
    always begin
        bit [10:0] e;
        @(posedge clk);
        #1;
        total++;
        if (expq.size() == 0) begin
            bad++;
            if (prints < 30) begin
                prints++;
                $display("FAIL scoreboard_empty: got pisos=%h nuevo=%b, wanted a queued expectation", pisos, nuevo);
            end
        end else begin
            e = expq.pop_front();
            if (pisos !== e[10:1]) begin
                bad++;
                if (prints < 30) begin
                    prints++;
                    $display("FAIL pisos @%0t: got %h wanted %h", $time, pisos, e[10:1]);
                end
            end
            total++;
            if (nuevo !== e[0]) begin
                bad++;
                if (prints < 30) begin
                    prints++;
                    $display("FAIL nuevo @%0t: got %b wanted %b", $time, nuevo, e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic medir(input string nombre);
        int n;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (nuevo) begin
                n = k;
                break;
            end
        end
        total++;
        if (n != LAT) begin
            bad++;
            $display("FAIL %s: nuevo after %0d edges, wanted %0d", nombre, n, LAT);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        botones        = 10'h3FF;
        piso_actual    = 2'd0;
        puerta_abierta = 1'b0;
        ciclos(4);

        // release reset with buttons idle
        reset_n = 1'b1;
        botones = 10'h000;
        ciclos(12);

        // cabin press, floor 2
        botones[2] = 1'b1;
        medir("cabin_latency");
        ciclos(3);
        botones[2] = 1'b0;
        ciclos(12);

        // glitch rejection then acceptance on hall-up floor 1
        botones[5] = 1'b1; ciclos(3); botones[5] = 1'b0; ciclos(14);
        botones[5] = 1'b1; ciclos(4); botones[5] = 1'b0; ciclos(14);

        // request everything, then serve floor 1 and floor 3
        botones = 10'h3FF; ciclos(12);
        botones = 10'h000; ciclos(12);
        piso_actual = 2'd1; puerta_abierta = 1'b1; ciclos(1);
        puerta_abierta = 1'b0; ciclos(2);
        piso_actual = 2'd3; puerta_abierta = 1'b1; ciclos(1);
        puerta_abierta = 1'b0; ciclos(2);

        // clear beats set on floor 0 while bit 3 sets independently
        piso_actual = 2'd0; puerta_abierta = 1'b1; ciclos(2);
        botones[0] = 1'b1; botones[3] = 1'b1;
        ciclos(14);
        puerta_abierta = 1'b0;
        botones = 10'h000; ciclos(12);

        // held button is not re-requested after service
        botones[1] = 1'b1; ciclos(12);
        piso_actual = 2'd1; puerta_abierta = 1'b1; ciclos(3);
        puerta_abierta = 1'b0; ciclos(16);
        botones[1] = 1'b0; ciclos(12);
        botones[1] = 1'b1; ciclos(12);
        botones[1] = 1'b0; ciclos(12);

        // reset mid-debounce, button kept held
        botones[8] = 1'b1; ciclos(2);
        reset_n = 1'b0; ciclos(2);
        reset_n = 1'b1;
        medir("reset_mid_debounce_latency");
        ciclos(2);
        botones = 10'h000; ciclos(12);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            botones        = botones ^ ($urandom() & ($urandom() & 10'h3FF));
            piso_actual    = 2'($urandom_range(0, 3));
            puerta_abierta = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) begin
                reset_n = 1'b0; ciclos(1); reset_n = 1'b1;
            end
            ciclos($urandom_range(1, 7));
        end

        botones        = 10'h000;
        puerta_abierta = 1'b0;
        ciclos(3);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
